// File: rtl/watch_set_ctrl.sv
// watch_set_ctrl: turns debounced buttons into single-cycle adjust pulses for
// the watch datapath, with field selection, auto-repeat, idle timeout and blink.
module watch_set_ctrl #(
    parameter int unsigned HOLD_DELAY    = 50_000_000,
    parameter int unsigned REPEAT_PERIOD = 10_000_000,
    parameter int unsigned IDLE_TIMEOUT  = 1_000_000_000,
    parameter int unsigned BLINK_HALF    = 25_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_btn_sel,
    input  logic       i_btn_up,
    input  logic       i_btn_down,
    output logic       o_tick_sec_up,
    output logic       o_tick_sec_down,
    output logic       o_tick_min_up,
    output logic       o_tick_min_down,
    output logic       o_tick_hour_up,
    output logic       o_tick_hour_down,
    output logic       o_edit,
    output logic [1:0] o_field,
    output logic       o_blink
);

    localparam int unsigned HOLD_MAX = (HOLD_DELAY > REPEAT_PERIOD) ? HOLD_DELAY : REPEAT_PERIOD;
    localparam int unsigned HOLD_W   = $clog2(HOLD_MAX + 1) + 1;
    localparam int unsigned IDLE_W   = $clog2(IDLE_TIMEOUT + 1) + 1;
    localparam int unsigned BLINK_W  = $clog2(BLINK_HALF + 1) + 1;

    typedef enum logic [1:0] {
        ST_RUN  = 2'd0,
        ST_HOUR = 2'd1,
        ST_MIN  = 2'd2,
        ST_SEC  = 2'd3
    } state_t;

    state_t              state;
    state_t              state_adv;
    logic                up_q;
    logic                down_q;
    logic                hold_active;
    logic                hold_down;
    logic                hold_rpt;
    logic [HOLD_W-1:0]   hold_cnt;
    logic [IDLE_W-1:0]   idle_cnt;
    logic [BLINK_W-1:0]  blink_cnt;

    logic                in_set;
    logic                one_btn;
    logic                press_rise;
    logic                btn_idle;
    logic                timeout;
    logic                fire;
    logic                hold_active_nx;
    logic                hold_down_nx;
    logic                hold_rpt_nx;
    logic [HOLD_W-1:0]   hold_cnt_nx;

    // Button qualification, idle-timeout detect and field advance order
    always_comb begin
        in_set     = (state != ST_RUN);
        one_btn    = i_btn_up ^ i_btn_down;
        press_rise = one_btn & (i_btn_up ? ~up_q : ~down_q);
        btn_idle   = ~i_btn_up & ~i_btn_down;
        timeout    = in_set & ~i_btn_sel & btn_idle &
                     (idle_cnt == IDLE_W'(IDLE_TIMEOUT - 1));
        case (state)
            ST_RUN:  state_adv = ST_HOUR;
            ST_HOUR: state_adv = ST_MIN;
            ST_MIN:  state_adv = ST_SEC;
            default: state_adv = ST_RUN;
        endcase
    end

    // Press-and-hold tracking: first pulse on the rising edge, then after
    // HOLD_DELAY, then every REPEAT_PERIOD; any break in the press drops it
    always_comb begin
        fire           = 1'b0;
        hold_active_nx = 1'b0;
        hold_down_nx   = hold_down;
        hold_rpt_nx    = 1'b0;
        hold_cnt_nx    = '0;
        if (in_set && !i_btn_sel && one_btn) begin
            if (press_rise) begin
                fire           = 1'b1;
                hold_active_nx = 1'b1;
                hold_down_nx   = i_btn_down;
                hold_cnt_nx    = HOLD_W'(1);
            end else if (hold_active && (hold_down == i_btn_down)) begin
                hold_active_nx = 1'b1;
                hold_rpt_nx    = hold_rpt;
                if (!hold_rpt && (hold_cnt == HOLD_W'(HOLD_DELAY))) begin
                    fire        = 1'b1;
                    hold_rpt_nx = 1'b1;
                    hold_cnt_nx = HOLD_W'(1);
                end else if (hold_rpt && (hold_cnt == HOLD_W'(REPEAT_PERIOD))) begin
                    fire        = 1'b1;
                    hold_cnt_nx = HOLD_W'(1);
                end else begin
                    hold_cnt_nx = hold_cnt + HOLD_W'(1);
                end
            end
        end
    end

    // Field FSM, counters, registered pulse routing and display flags
    always_ff @(posedge clk) begin
        if (rst) begin
            state            <= ST_RUN;
            up_q             <= 1'b0;
            down_q           <= 1'b0;
            hold_active      <= 1'b0;
            hold_down        <= 1'b0;
            hold_rpt         <= 1'b0;
            hold_cnt         <= '0;
            idle_cnt         <= '0;
            blink_cnt        <= '0;
            o_tick_sec_up    <= 1'b0;
            o_tick_sec_down  <= 1'b0;
            o_tick_min_up    <= 1'b0;
            o_tick_min_down  <= 1'b0;
            o_tick_hour_up   <= 1'b0;
            o_tick_hour_down <= 1'b0;
            o_edit           <= 1'b0;
            o_field          <= 2'd0;
            o_blink          <= 1'b0;
        end else begin
            up_q        <= i_btn_up;
            down_q      <= i_btn_down;
            hold_active <= hold_active_nx;
            hold_down   <= hold_down_nx;
            hold_rpt    <= hold_rpt_nx;
            hold_cnt    <= hold_cnt_nx;

            o_tick_hour_up   <= fire & (state == ST_HOUR) & ~i_btn_down;
            o_tick_hour_down <= fire & (state == ST_HOUR) &  i_btn_down;
            o_tick_min_up    <= fire & (state == ST_MIN)  & ~i_btn_down;
            o_tick_min_down  <= fire & (state == ST_MIN)  &  i_btn_down;
            o_tick_sec_up    <= fire & (state == ST_SEC)  & ~i_btn_down;
            o_tick_sec_down  <= fire & (state == ST_SEC)  &  i_btn_down;

            if (i_btn_sel) begin
                state     <= state_adv;
                o_field   <= 2'(state_adv);
                o_edit    <= (state_adv != ST_RUN);
                o_blink   <= (state_adv != ST_RUN);
                blink_cnt <= '0;
                idle_cnt  <= '0;
            end else if (timeout) begin
                state     <= ST_RUN;
                o_field   <= 2'd0;
                o_edit    <= 1'b0;
                o_blink   <= 1'b0;
                blink_cnt <= '0;
                idle_cnt  <= '0;
            end else if (in_set) begin
                idle_cnt <= btn_idle ? idle_cnt + IDLE_W'(1) : '0;
                if (blink_cnt == BLINK_W'(BLINK_HALF - 1)) begin
                    o_blink   <= ~o_blink;
                    blink_cnt <= '0;
                end else begin
                    blink_cnt <= blink_cnt + BLINK_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_watch_set_ctrl.sv
// tb_watch_set_ctrl: vector table, directed sequences and random stimulus
// against a cycle-level reference model of the watch set controller.
module tb_watch_set_ctrl;

    localparam int HD = 10;
    localparam int RP = 4;
    localparam int IT = 50;
    localparam int BH = 5;

    logic       clk = 1'b0;
    logic       rst, sel, up, dn;
    logic       t_su, t_sd, t_mu, t_md, t_hu, t_hd;
    logic [1:0] field;
    logic       edit, blink;

    int errors = 0;
    int checks = 0;

    // reference model state
    int         m_field, m_since, m_idle, m_k, m_dir;
    logic       m_pu, m_pd;
    logic [5:0] m_ticks;

    logic       r_up, r_dn;

    typedef struct packed {
        logic       r, s, u, d;
        logic [5:0] ticks;
        logic [1:0] fld;
        logic       ed, bl;
    } vec_t;
    vec_t tbl [10];

    always #5 clk = ~clk;

    watch_set_ctrl #(
        .HOLD_DELAY    (HD),
        .REPEAT_PERIOD (RP),
        .IDLE_TIMEOUT  (IT),
        .BLINK_HALF    (BH)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .i_btn_sel        (sel),
        .i_btn_up         (up),
        .i_btn_down       (dn),
        .o_tick_sec_up    (t_su),
        .o_tick_sec_down  (t_sd),
        .o_tick_min_up    (t_mu),
        .o_tick_min_down  (t_md),
        .o_tick_hour_up   (t_hu),
        .o_tick_hour_down (t_hd),
        .o_edit           (edit),
        .o_field          (field),
        .o_blink          (blink)
    );

    // bit0 hour_up, bit1 hour_down, bit2 min_up, bit3 min_down, bit4 sec_up, bit5 sec_down
    function automatic logic [5:0] dut_ticks();
        return {t_sd, t_su, t_md, t_mu, t_hd, t_hu};
    endfunction

    function automatic logic [31:0] dut_vec();
        return {22'd0, dut_ticks(), field, edit, blink};
    endfunction

    function automatic logic [31:0] model_vec();
        logic set;
        set = (m_field != 0);
        return {22'd0, m_ticks, 2'(m_field), set, set && (((m_since / BH) % 2) == 0)};
    endfunction

    // held cycle k (k=1 is the rising-edge sample) pulses at 1, 1+HD, then every RP
    function automatic bit is_pulse(input int k);
        return (k == 1) || (k == 1 + HD) || ((k > 1 + HD) && (((k - 1 - HD) % RP) == 0));
    endfunction

    task automatic model_step(input logic r, input logic s, input logic u, input logic d);
        bit one, rising, in_set;
        m_ticks = '0;
        if (r) begin
            m_field = 0; m_since = 0; m_idle = 0; m_k = 0; m_dir = 0;
            m_pu = 1'b0; m_pd = 1'b0;
            return;
        end
        in_set = (m_field != 0);
        one    = u ^ d;
        rising = one && (u ? !m_pu : !m_pd);
        if (s) begin
            m_field = (m_field + 1) % 4;
            m_since = 0;
            m_idle  = 0;
            m_k     = 0;
        end else begin
            if (in_set && one && (rising || (m_k > 0 && m_dir == int'(d)))) begin
                m_k   = rising ? 1 : m_k + 1;
                m_dir = int'(d);
                if (is_pulse(m_k)) m_ticks[(m_field - 1) * 2 + m_dir] = 1'b1;
            end else begin
                m_k = 0;
            end
            if (in_set) begin
                m_idle = (u || d) ? 0 : m_idle + 1;
                m_since++;
                if (m_idle == IT) begin
                    m_field = 0; m_idle = 0; m_k = 0;
                end
            end
        end
        m_pu = u;
        m_pd = d;
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%0h expected=%0h", name, got, exp);
        end
    endtask

    // drive one sample, advance one edge, compare against the model
    task automatic step(input logic r, input logic s, input logic u, input logic d, input string name);
        rst = r; sel = s; up = u; dn = d;
        @(posedge clk);
        #1;
        model_step(r, s, u, d);
        check(name, dut_vec(), model_vec());
    endtask

    initial begin
        logic [5:0]  acc;
        logic [31:0] mask, exp_mask;
        logic [14:0] bpat;

        rst = 1'b1; sel = 1'b0; up = 1'b0; dn = 1'b0;
        r_up = 1'b0; r_dn = 1'b0;
        m_field = 0; m_since = 0; m_idle = 0; m_k = 0; m_dir = 0;
        m_pu = 1'b0; m_pd = 1'b0; m_ticks = '0;
        #1;

        // r s u d  ticks      field ed bl
        tbl[0] = '{1'b1, 1'b0, 1'b0, 1'b0, 6'b000000, 2'd0, 1'b0, 1'b0};
        tbl[1] = '{1'b0, 1'b1, 1'b0, 1'b0, 6'b000000, 2'd1, 1'b1, 1'b1};
        tbl[2] = '{1'b0, 1'b0, 1'b1, 1'b0, 6'b000001, 2'd1, 1'b1, 1'b1};
        tbl[3] = '{1'b0, 1'b0, 1'b0, 1'b0, 6'b000000, 2'd1, 1'b1, 1'b1};
        tbl[4] = '{1'b0, 1'b1, 1'b1, 1'b0, 6'b000000, 2'd2, 1'b1, 1'b1};
        tbl[5] = '{1'b0, 1'b0, 1'b1, 1'b0, 6'b000000, 2'd2, 1'b1, 1'b1};
        tbl[6] = '{1'b0, 1'b0, 1'b0, 1'b0, 6'b000000, 2'd2, 1'b1, 1'b1};
        tbl[7] = '{1'b0, 1'b0, 1'b0, 1'b1, 6'b001000, 2'd2, 1'b1, 1'b1};
        tbl[8] = '{1'b1, 1'b0, 1'b0, 1'b1, 6'b000000, 2'd0, 1'b0, 1'b0};
        tbl[9] = '{1'b0, 1'b0, 1'b0, 1'b1, 6'b000000, 2'd0, 1'b0, 1'b0};
        for (int i = 0; i < 10; i++) begin
            step(tbl[i].r, tbl[i].s, tbl[i].u, tbl[i].d, $sformatf("model_vec%0d", i));
            check($sformatf("table_vec%0d", i), dut_vec(),
                  {22'd0, tbl[i].ticks, tbl[i].fld, tbl[i].ed, tbl[i].bl});
        end

        // holding up in RUN never adjusts
        step(1, 0, 0, 0, "run_rst");
        acc = '0;
        for (int i = 0; i < 20; i++) begin
            step(0, 0, 1, 0, "run_hold");
            acc |= dut_ticks();
        end
        check("run_hold_ticks", {26'd0, acc}, 32'd0);
        check("run_hold_outs", {29'd0, field, edit, blink}, 32'd0);
        step(0, 0, 0, 0, "run_release");

        // hold down 30 cycles in SET_MIN: pulses after held cycles 1,11,15,19,23,27
        step(1, 0, 0, 0, "min_rst");
        step(0, 1, 0, 0, "min_sel1");
        step(0, 1, 0, 0, "min_sel2");
        mask = '0; acc = '0;
        for (int k = 1; k <= 30; k++) begin
            step(0, 0, 0, 1, "min_hold");
            if (t_md) mask[k] = 1'b1;
            acc |= dut_ticks();
        end
        exp_mask = '0;
        exp_mask[1] = 1'b1; exp_mask[11] = 1'b1; exp_mask[15] = 1'b1;
        exp_mask[19] = 1'b1; exp_mask[23] = 1'b1; exp_mask[27] = 1'b1;
        check("min_down_pulse_cycles", mask, exp_mask);
        check("min_hold_other_ticks", {26'd0, acc & 6'b110111}, 32'd0);
        step(0, 0, 0, 0, "min_release");

        // both buttons held in SET_SEC, then up released: no pulses at all
        step(1, 0, 0, 0, "both_rst");
        for (int i = 0; i < 3; i++) step(0, 1, 0, 0, "both_sel");
        acc = '0;
        for (int i = 0; i < 20; i++) begin
            step(0, 0, 1, 1, "both_hold");
            acc |= dut_ticks();
        end
        for (int i = 0; i < 10; i++) begin
            step(0, 0, 0, 1, "both_then_down");
            acc |= dut_ticks();
        end
        check("both_hold_ticks", {26'd0, acc}, 32'd0);
        step(0, 0, 0, 0, "both_release");

        // idle timeout from SET_SEC on the 50th idle edge
        step(1, 0, 0, 0, "idle_rst");
        for (int i = 0; i < 3; i++) step(0, 1, 0, 0, "idle_sel");
        for (int i = 1; i <= IT; i++) begin
            step(0, 0, 0, 0, "idle_wait");
            if (i == IT - 1) check("idle_before_timeout", {30'd0, field}, 32'd3);
        end
        check("idle_timeout_outs", {29'd0, field, edit, blink}, 32'd0);

        // a press at idle cycle 40 restarts the timeout window
        for (int i = 0; i < 3; i++) step(0, 1, 0, 0, "idle2_sel");
        for (int i = 1; i < 40; i++) step(0, 0, 0, 0, "idle2_wait");
        step(0, 0, 1, 0, "idle2_press");
        for (int i = 1; i <= IT; i++) begin
            step(0, 0, 0, 0, "idle2_after");
            if (i == IT - 1) check("idle2_before_timeout", {30'd0, field}, 32'd3);
        end
        check("idle2_timeout_field", {30'd0, field}, 32'd0);

        // four sel pulses walk the fields
        step(1, 0, 0, 0, "walk_rst");
        for (int i = 1; i <= 4; i++) begin
            step(0, 1, 0, 0, "walk_sel");
            check($sformatf("walk_field%0d", i), {30'd0, field}, 32'(i % 4));
        end

        // blink toggles every BH cycles, starting high on entry
        bpat = 15'b111110000011111;
        step(0, 1, 0, 0, "blink_sel");
        check("blink_n0", {31'd0, blink}, {31'd0, bpat[0]});
        for (int n = 1; n < 15; n++) begin
            step(0, 0, 0, 0, "blink_wait");
            check($sformatf("blink_n%0d", n), {31'd0, blink}, {31'd0, bpat[n]});
        end

        // reset mid-hold clears everything on the next edge
        step(0, 0, 1, 0, "midhold_press");
        for (int i = 0; i < 12; i++) step(0, 0, 1, 0, "midhold_hold");
        step(1, 0, 1, 0, "midhold_rst");
        check("midhold_rst_outs", dut_vec(), 32'd0);
        step(0, 0, 1, 0, "midhold_after_rst");
        check("midhold_after_rst_outs", dut_vec(), 32'd0);

        // randomized run against the model
        step(1, 0, 0, 0, "rand_rst");
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 11) == 0) r_up = ~r_up;
            if ($urandom_range(0, 14) == 0) r_dn = ~r_dn;
            step(logic'($urandom_range(0, 499) == 0), logic'($urandom_range(0, 19) == 0),
                 r_up, r_dn, "rand");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/watch_set_ctrl.md
Name: watch_set_ctrl

Overview:
- Control unit for the watch datapath.
- Converts debounced user buttons into the six single-cycle adjust pulses the datapath consumes: sec/min/hour × up/down.
- Runs a field-select FSM (RUN, SET_HOUR, SET_MIN, SET_SEC) with press-and-hold auto-repeat, idle timeout back to RUN, and a blink flag for the display driver.
- Sits between the button debouncers and the watch datapath. Timekeeping keeps running during edit.

Parameters:
- HOLD_DELAY, 50_000_000: cycles from first press sample to first auto-repeat pulse (0.5 s at 100 MHz).
- REPEAT_PERIOD, 10_000_000: cycles between subsequent auto-repeat pulses (0.1 s).
- IDLE_TIMEOUT, 1_000_000_000: idle cycles in any SET state before returning to RUN (10 s).
- BLINK_HALF, 25_000_000: cycles per half-period of o_blink.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset. One clock; reset is synchronous and active-high.
- i_btn_sel  in  1  one-cycle pulse from a debounced edge detector; advances the field.
- i_btn_up  in  1  debounced level, high while the up button is held.
- i_btn_down  in  1  debounced level, high while the down button is held.
- o_tick_sec_up, o_tick_sec_down, o_tick_min_up, o_tick_min_down, o_tick_hour_up, o_tick_hour_down  out  1 each  registered one-cycle adjust pulses.
- o_edit  out  1  high in any SET state.
- o_field  out  2  0=RUN, 1=HOUR, 2=MIN, 3=SEC.
- o_blink  out  1  blink enable for the selected field's digits.

Behaviour:
- Reset (sampled on a clk edge with rst=1):
  - state=RUN; every output 0.
  - All counters 0.
  - Button history registers 0.
- FSM:
  - A sample with i_btn_sel=1 advances RUN→SET_HOUR→SET_MIN→SET_SEC→RUN.
  - IDLE_TIMEOUT expiry in any SET state forces RUN.
  - o_field and o_edit are registered and update on the same edge as the state.
- Valid press:
  - Requires exactly one of i_btn_up/i_btn_down sampled high, while in a SET state.
  - Both high counts as no press: the hold counter clears and no pulses are issued. After both are released to a single button, that press needs a fresh rising edge of that button.
- Auto-repeat, counting held cycle 1 as the first sample where the button is high after being low:
  - Pulses occur on held cycles 1, 1+HOLD_DELAY, 1+HOLD_DELAY+REPEAT_PERIOD, then every REPEAT_PERIOD while held.
  - Each pulse appears on the output in the cycle after the qualifying sample (1-cycle latency).
- Pulse routing: the current field and direction select exactly one of the six outputs. At most one output is high in any cycle. All six are 0 in RUN.
- Field change while holding:
  - The hold counter clears.
  - No further pulses until the button is released and pressed again; a held button counts as already pressed.
- Same-cycle i_btn_sel and rising up/down edge: sel wins, the field advances, and no adjust pulse is generated.
- Button edge history registers update every cycle in all states. A button already held when entering a SET state does not pulse.
- Idle counter:
  - Clears on entry to a SET state, on an i_btn_sel sample, or on any cycle with i_btn_up or i_btn_down high.
  - Otherwise increments in SET states.
  - On the IDLE_TIMEOUT-th consecutive idle cycle, state goes to RUN on that edge.
  - Holding a button never times out.
- Blink:
  - o_blink=0 in RUN.
  - On entry to any SET state, including field advance, o_blink=1 and the blink counter clears.
  - o_blink toggles every BLINK_HALF cycles thereafter.
- Counter widths: each counter is $clog2 of its parameter plus margin, so it never wraps within its parameter range.
- Reset mid-hold or mid-edit: immediate return to reset values. No pulse in the cycle after reset.

Test Plan:
Common bench parameters: HOLD_DELAY=10, REPEAT_PERIOD=4, IDLE_TIMEOUT=50, BLINK_HALF=5.
1. Reset, then hold i_btn_up 20 cycles in RUN → all six ticks stay 0; o_field=0, o_edit=0, o_blink=0.
2. One sel pulse, then i_btn_up high for 1 cycle → o_field=1, o_edit=1, and exactly one o_tick_hour_up pulse, 1 cycle after the up sample.
3. Two sel pulses (SET_MIN), then hold i_btn_down 30 cycles → o_tick_min_down pulses after held cycles 1, 11, 15, 19, 23, 27 (6 pulses); no other tick asserts.
4. In SET_SEC, both buttons high 20 cycles, then release up only → zero pulses throughout, including after up is released.
5. In SET_SEC, 50 idle cycles → o_field 3→0, o_edit 0, o_blink 0 on the 50th idle edge. A repeat run with a 1-cycle up press at idle cycle 40 → no timeout until 50 cycles after that press.
6. Check each of the following:
   - Four sel pulses → o_field steps 1, 2, 3, 0.
   - sel coincident with an up rising edge in SET_HOUR → o_field=2 and no tick pulse.
   - In a SET state, o_blink toggles every 5 cycles starting at 1.
   - rst asserted mid-hold → all outputs 0 on the next edge.
